// File: rtl/add_serial_arb.sv
// add_serial_arb: 4-way arbiter sharing one multi-cycle 8-bit serial adder.
// Define ADD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module add_serial_arb #(
  parameter int ADD_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  gnt,
  output logic [3:0]  rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        adder_start,
  output logic [7:0]  adder_a,
  output logic [7:0]  adder_b,
  input  logic [7:0]  adder_out
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(ADD_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       adder_start_q, adder_start_d;
  logic [7:0] adder_a_q, adder_a_d;
  logic [7:0] adder_b_q, adder_b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] win;

`ifdef ADD_ARB_RR_EN
  logic [1:0] last_q, last_d;

  // Descending loop: the smallest offset from last_q is written last and wins.
  always_comb begin
    win = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[last_q + 2'(k)]) win = last_q + 2'(k);
    end
  end
`else
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    gnt_d         = 4'b0000;
    rsp_valid_d   = 4'b0000;
    rsp_data_d    = rsp_data_q;
    adder_start_d = 1'b0;
    adder_a_d     = adder_a_q;
    adder_b_d     = adder_b_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
`ifdef ADD_ARB_RR_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d         = 4'b0001 << win;
          adder_start_d = 1'b1;
          adder_a_d     = req_a[{win, 3'b000} +: 8];
          adder_b_d     = req_b[{win, 3'b000} +: 8];
          owner_d       = win;
          cnt_d         = 8'd0;
          state_d       = WAIT;
`ifdef ADD_ARB_RR_EN
          last_d        = win;
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rsp_data_d  = adder_out;
          rsp_valid_d = 4'b0001 << owner_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= 4'b0000;
      rsp_valid_q   <= 4'b0000;
      rsp_data_q    <= 8'd0;
      adder_start_q <= 1'b0;
      adder_a_q     <= 8'd0;
      adder_b_q     <= 8'd0;
      cnt_q         <= 8'd0;
      owner_q       <= 2'd0;
`ifdef ADD_ARB_RR_EN
      last_q        <= 2'd3;
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      adder_start_q <= adder_start_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
`ifdef ADD_ARB_RR_EN
      last_q        <= last_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign adder_start = adder_start_q;
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_add_serial_arb.sv
// Self-checking bench for add_serial_arb: vector table plus reset and contention sequences.
module tb_add_serial_arb;
  localparam int ADD_LAT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_a, req_b;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_data, adder_a, adder_b, adder_out;
  logic        busy, adder_start;

  add_serial_arb #(.ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b),
    .adder_out(adder_out)
  );

  // Adder model: operands are held stable from start, so the sum is valid well before sampling.
  assign adder_out = adder_a + adder_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  eg;
    int          hold;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [3:0] m);
    int r = 0;
    for (int i = 0; i < 4; i++) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    int w = 0;
`ifdef ADD_ARB_RR_EN
    for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) w = (last + k) % 4;
`else
    for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`endif
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 0 || rsp_valid != 0) begin
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("rsp_onehot", 32'($countones(rsp_valid) <= 1), 32'd1);
        chk("gnt_rsp_excl", 32'((|gnt) && (|rsp_valid)), 32'd0);
      end
      if (rsp_valid != 0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid %0h data %0h expected none", rsp_valid, rsp_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_valid", rsp_valid, e.v);
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_gnt(output bit got);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_txn(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] eg, input int hold);
    bit         got;
    int         w;
    exp_t       e;
    logic [7:0] s;
    @(negedge clk);
    req = r; req_a = a; req_b = b;
    wait_gnt(got);
    if (!got) begin
      req = '0;
      return;
    end
    w = idx_of(eg);
    s = a[8*w +: 8] + b[8*w +: 8];
    chk("gnt", gnt, eg);
    chk("adder_start", adder_start, 1'b1);
    chk("busy_g", busy, 1'b1);
    chk("adder_a", adder_a, a[8*w +: 8]);
    chk("adder_b", adder_b, b[8*w +: 8]);
    e.v = eg; e.d = s; e.cyc = cyc + ADD_LAT;
    sbq.push_back(e);
    req_a = $urandom; req_b = $urandom;
    if (hold == 0) req = '0;
    @(negedge clk);
    chk("gnt_drop", gnt, 4'b0000);
    chk("start_drop", adder_start, 1'b0);
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      req = '0;
    end
    wait_idle();
    chk("sb_drained", sbq.size(), 0);
    chk("rsp_data_hold", rsp_data, s);
  endtask

  initial begin
    bit   got;
    int   nrsp;
    int   lastm;
    int   prev;
    int   w;
    exp_t e;

    vecs[0] = '{4'b0001, 32'hDDCCBB12, 32'h99887734, 4'b0001, 0};
    vecs[1] = '{4'b0010, 32'h0000FF00, 32'h00000100, 4'b0010, 0};
    vecs[2] = '{4'b0100, 32'h115A2233, 32'h66217788, 4'b0100, 3};
    vecs[3] = '{4'b1000, 32'h7F000000, 32'h01000000, 4'b1000, 0};
    vecs[4] = '{4'b0110, 32'h0033AA00, 32'h00CC0500, 4'b0010, 0};
`ifdef ADD_ARB_RR_EN
    vecs[5] = '{4'b1001, 32'h10000020, 32'h02000003, 4'b1000, 0};
`else
    vecs[5] = '{4'b1001, 32'h10000020, 32'h02000003, 4'b0001, 0};
`endif

    rst = 1'b1; req = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", adder_start, 1'b0);
    chk("rst_adder_a", adder_a, 8'h00);
    chk("rst_adder_b", adder_b, 8'h00);
    rst = 1'b0;

    // Idle with no request must stay quiet.
    repeat (4) begin
      @(negedge clk);
      chk("idle_gnt", gnt, 4'b0000);
      chk("idle_busy", busy, 1'b0);
    end

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].eg, vecs[i].hold);

    // Reset in the middle of a transaction aborts it without a response.
    @(negedge clk);
    req = 4'b0001; req_a = 32'h000000AB; req_b = 32'h00000011;
    wait_gnt(got);
    chk("abort_gnt", gnt, 4'b0001);
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 4'b0000);
    chk("abort_rsp_data", rsp_data, 8'h00);
    chk("abort_adder_a", adder_a, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    nrsp = 0;
    repeat (ADD_LAT + 4) begin
      @(negedge clk);
      if (rsp_valid != 0) nrsp++;
    end
    chk("abort_no_rsp", nrsp, 0);
    do_txn(4'b1000, 32'h3C000000, 32'h05000000, 4'b1000, 0);

    // Reset again so round-robin history starts at last=3.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // All four requesting continuously.
    @(negedge clk);
    req = 4'b1111; req_a = 32'h40302010; req_b = 32'h04030201;
    lastm = 3;
    prev  = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(got);
      if (!got) break;
      w = pick(req, lastm);
      chk("cont_gnt", gnt, 4'b0001 << w);
      if (g > 0) chk("cont_spacing", cyc - prev, ADD_LAT + 2);
      prev = cyc;
      e.v = 4'b0001 << w; e.d = req_a[8*w +: 8] + req_b[8*w +: 8]; e.cyc = cyc + ADD_LAT;
      sbq.push_back(e);
      lastm = w;
      if (g == 4) req = '0;
    end
    req = '0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_serial_arb.md
ADD_SERIAL_ARB -- requirements
Module: add_serial_arb

Interface
REQ-001 Parameter ADD_LAT, default 10, cycles from adder start to valid adder result; legal range 2..255.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester request, level, held until granted.
REQ-005 req_a  input  32  operand A, requester i on bits [8i+7:8i].
REQ-006 req_b  input  32  operand B, same packing as req_a.
REQ-007 gnt  output  4  one-hot grant pulse, one cycle.
REQ-008 rsp_valid  output  4  one-hot response pulse, one cycle.
REQ-009 rsp_data  output  8  sum for the requester flagged in rsp_valid.
REQ-010 busy  output  1  high while a transaction is in flight (state != IDLE).
REQ-011 adder_start  output  1  one-cycle start pulse to the shared serial adder.
REQ-012 adder_a, adder_b  output  8 each  operands to the shared adder, stable from start until next grant.
REQ-013 adder_out  input  8  result from the shared adder.

Function
REQ-014 The block SHALL be a 3-state FSM: IDLE, WAIT, RESP.
REQ-015 IDLE with req==0 SHALL stay IDLE with gnt, adder_start, rsp_valid all 0.
REQ-016 IDLE with req!=0 SHALL on the edge select winner w, register gnt=1<<w, adder_start=1, adder_a/adder_b=operands of w, owner=w, cnt=0, go WAIT.
REQ-017 Grant cycle G (gnt, adder_start visible) SHALL be the cycle after the deciding edge; both drop to 0 in G+1.
REQ-018 WAIT SHALL increment 8-bit cnt each cycle; when cnt==ADD_LAT-1 it goes to RESP.
REQ-019 Entering RESP SHALL register rsp_data=adder_out and rsp_valid=1<<owner; rsp_valid visible exactly in cycle G+ADD_LAT, one cycle only.
REQ-020 RESP SHALL return to IDLE unconditionally; earliest next gnt in cycle G+ADD_LAT+2.
REQ-021 rsp_data SHALL hold its value until the next response.
REQ-022 req changes or deassertion after grant SHALL not affect an in-flight transaction; the response is still delivered to owner.
REQ-023 Operand inputs of non-granted requesters SHALL be ignored; operands sampled only at the granting edge.
REQ-024 At most one bit of gnt and of rsp_valid SHALL ever be set; gnt and rsp_valid never high in the same cycle.
REQ-025 Arbitration SHALL be decided only in IDLE; requests arriving in WAIT/RESP wait.

Reset
REQ-026 rst SHALL force state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, adder_start=0, adder_a=0, adder_b=0, cnt=0, owner=0, busy=0, last=3.
REQ-027 rst mid-transaction SHALL abort it with no response; first grant after release follows REQ-016 with last=3.

Configuration
REQ-028 Macro ADD_ARB_RR_EN defined: round-robin; search starts at (last+1) mod 4, wraps, last updated to w at each grant.
REQ-029 ADD_ARB_RR_EN undefined: fixed priority, lowest index wins; last register absent.

Verification
REQ-030 Single: req=0001, a0=8'h12, b0=8'h34, adder model result after ADD_LAT=10 -> gnt=0001 in G, adder_start pulse, rsp_valid=0001, rsp_data=8'h46 in G+10.
REQ-031 All 4 requesting continuously, RR_EN defined -> grant order 0,1,2,3,0 with grants spaced ADD_LAT+2 cycles.
REQ-032 Same stimulus, RR_EN undefined -> requester 0 granted every time while req[0] held.
REQ-033 Overflow: a=8'hFF, b=8'h01 -> rsp_data=8'h00 (carry discarded).
REQ-034 req[2] dropped in cycle G+3 of its grant -> rsp_valid=0100 still in G+10.
REQ-035 rst pulsed in cycle G+5 -> no rsp_valid, busy=0 next cycle, re-request of req=1000 -> gnt=1000 per REQ-016.
